mux_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one output datapath among N_REQ requesters by driving an N:1 data multiplexer select. Each requester presents valid/data/last. A grant is locked for a whole packet and released on the last beat, or forcibly after MAX_BEATS beats. The selected beat passes through a registered output stage with a valid/ready handshake, so the block sits between several producers and one downstream consumer.

---
 rtl/mux_arb_pkg.sv | 10 +
 rtl/rr_priority_pick.sv | 24 ++
 rtl/mux_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared arbiter state encoding and parameter legality checks
package mux_arb_pkg;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
   function automatic bit max_beats_ok(input int m);
      return (m >= 1) && (m <= 65535);
   endfunction
   function automatic bit n_req_ok(input int n);
      return (n >= 2) && (n <= 16);
   endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request searching upward from i_ptr with wrap
// Ports: i_req request vector, i_ptr search start, o_win winner index, o_any any request set
module rr_priority_pick #(
   parameter int N_REQ = 4,
   localparam int SEL_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [SEL_W-1:0] i_ptr,
   output logic [SEL_W-1:0] o_win,
   output logic             o_any
);
   logic [SEL_W:0] s;
   // Walk offsets from farthest to nearest so the nearest set request wins.
   always_comb begin
      o_win = '0;
      s = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         s = (SEL_W+1)'(i) + {1'b0, i_ptr};
         s = (s >= (SEL_W+1)'(N_REQ)) ? s - (SEL_W+1)'(N_REQ) : s;
         o_win = i_req[s[SEL_W-1:0]] ? s[SEL_W-1:0] : o_win;
      end
   end
   assign o_any = |i_req;
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin packet arbiter driving an N:1 mux into a registered valid/ready stage
// Ports: i_valid/i_data/i_last/o_ready per requester; o_valid/o_data/o_last/o_src/o_trunc/i_ready downstream;
//        o_busy high while a grant is held; i_clk, i_rst_n (async active-low)
module mux_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int DATA_W = 8,
   parameter int MAX_BEATS = 16,
   localparam int SEL_W = $clog2(N_REQ)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [N_REQ-1:0]        i_valid,
   input  logic [N_REQ*DATA_W-1:0] i_data,
   input  logic [N_REQ-1:0]        i_last,
   output logic [N_REQ-1:0]        o_ready,
   output logic                    o_valid,
   output logic [DATA_W-1:0]       o_data,
   output logic                    o_last,
   output logic [SEL_W-1:0]        o_src,
   input  logic                    i_ready,
   output logic                    o_busy,
   output logic                    o_trunc
);
   import mux_arb_pkg::*;
   localparam int CNT_W = $clog2(MAX_BEATS + 1);
   if (!max_beats_ok(MAX_BEATS)) begin : g_bad_max_beats
      $error("MAX_BEATS must be within 1..65535");
   end
   if (!n_req_ok(N_REQ)) begin : g_bad_n_req
      $error("N_REQ must be within 2..16");
   end
   state_t             state_q, state_d;
   logic [SEL_W-1:0]   grant_q, grant_d, ptr_q, ptr_d, src_q, src_d, win, ptr_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic               valid_q, valid_d, last_q, last_d, trunc_q, trunc_d;
   logic [DATA_W-1:0]  data_q, data_d, beat;
   logic               any, acc, hit_max, is_last, done;
   rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
      .i_req(i_valid),
      .i_ptr(ptr_q),
      .o_win(win),
      .o_any(any)
   );
   // Only the granted requester may be ready, and only when the output stage can take a beat.
   always_comb begin
      o_ready = '0;
      if (state_q == BUSY) o_ready[grant_q] = ~valid_q | i_ready;
   end
   always_comb begin
      beat = '0;
      for (int k = 0; k < N_REQ; k++)
         if (grant_q == SEL_W'(k)) beat = i_data[k*DATA_W +: DATA_W];
   end
   assign acc     = o_ready[grant_q] & i_valid[grant_q];
   assign is_last = i_last[grant_q];
   assign cnt_inc = cnt_q + 1'b1;
   assign hit_max = cnt_inc == CNT_W'(MAX_BEATS);
   assign done    = acc & (is_last | hit_max);
   assign ptr_nxt = (grant_q == SEL_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      src_d   = src_q;
      trunc_d = trunc_q;
      if (state_q == IDLE) begin
         state_d = any ? BUSY : IDLE;
         grant_d = any ? win : grant_q;
      end else if (acc) begin
         state_d = done ? IDLE : BUSY;
         ptr_d   = done ? ptr_nxt : ptr_q;
         cnt_d   = done ? '0 : cnt_inc;
      end
      if (acc) begin
         valid_d = 1'b1;
         data_d  = beat;
         last_d  = is_last | hit_max;
         src_d   = grant_q;
         trunc_d = hit_max & ~is_last;
      end else if (valid_q & i_ready) begin
         valid_d = 1'b0;
         trunc_d = 1'b0;
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         src_q   <= '0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
         src_q   <= src_d;
         trunc_q <= trunc_d;
      end
   end
   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_last  = last_q;
   assign o_src   = src_q;
   assign o_trunc = trunc_q;
   assign o_busy  = state_q == BUSY;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: scoreboard bench for the round-robin packet arbiter
module tb_mux_rr_arbiter;
   localparam int N = 4, W = 8, MAXB = 4, SW = 2;
   typedef struct packed {logic [W-1:0] d; logic l; logic [SW-1:0] s; logic t;} beat_t;
   logic           clk = 1'b0, rst_n = 1'b0, i_ready = 1'b1;
   logic [N-1:0]   valid = '0, last = '0;
   logic [N*W-1:0] data = '0;
   logic [N-1:0]   o_ready;
   logic           o_valid, o_last, o_busy, o_trunc;
   logic [W-1:0]   o_data;
   logic [SW-1:0]  o_src;
   beat_t          sb[$];
   beat_t          exp_b;
   int             src_log[$], t_log[$];
   int             checks = 0, errors = 0, cyc = 0;
   bit             log_en = 1'b0;

   mux_rr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BEATS(MAXB)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .i_last(last),
      .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_src(o_src),
      .i_ready(i_ready), .o_busy(o_busy), .o_trunc(o_trunc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: pop one expected beat per downstream handshake, sampled just before the edge.
   always @(negedge clk) begin
      #3;
      if (rst_n && o_valid && i_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got data=%h src=%0d, required no beat", o_data, o_src);
         end else begin
            exp_b = sb.pop_front();
            if ({o_data, o_last, o_src, o_trunc} !== exp_b) begin
               errors++;
               $display("FAIL beat: got data=%h last=%b src=%0d trunc=%b, required data=%h last=%b src=%0d trunc=%b",
                        o_data, o_last, o_src, o_trunc, exp_b.d, exp_b.l, exp_b.s, exp_b.t);
            end
         end
         if (log_en) begin
            src_log.push_back(int'(o_src));
            t_log.push_back(cyc);
         end
      end
   end

   // Drives one requester's beats; each accepted beat pushes its expected output, counting grant-local truncation.
   task automatic send_pkt(input int src, input int n, input logic [W-1:0] base, input bit end_last, output int waits);
      logic [W-1:0] d;
      bit lst, cap;
      int w;
      waits = 0;
      for (int b = 0; b < n; b++) begin
         d = base + W'(b);
         lst = end_last && (b == n - 1);
         cap = (b % MAXB) == MAXB - 1;
         valid[src] = 1'b1;
         last[src] = lst;
         data[src*W +: W] = d;
         w = 0;
         @(negedge clk); #3;
         while (!o_ready[src]) begin
            #10;
            w++;
            if (w > 60) begin
               checks++; errors++;
               $display("FAIL ready_timeout: requester %0d beat %0d got no o_ready within 60 cycles", src, b);
               valid[src] = 1'b0; last[src] = 1'b0;
               return;
            end
         end
         sb.push_back(beat_t'{d: d, l: lst | cap, s: SW'(src), t: cap & ~lst});
         waits += w;
         @(posedge clk); #1;
      end
      valid[src] = 1'b0;
      last[src] = 1'b0;
   endtask

   task automatic two_pkts(input int k);
      int w;
      send_pkt(k, 1, 8'h70 + W'(k), 1'b1, w);
      send_pkt(k, 1, 8'h78 + W'(k), 1'b1, w);
   endtask

   task automatic drain_check(input string name);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, sb.size());
      end
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if ({o_ready, o_valid, o_data, o_last, o_src, o_busy, o_trunc} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ready=%b valid=%b data=%h last=%b src=%0d busy=%b trunc=%b, required all 0",
                  o_ready, o_valid, o_data, o_last, o_src, o_busy, o_trunc);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      int w;
      log_en = 1'b1; src_log.delete(); t_log.delete();
      send_pkt(2, 3, 8'hA1, 1'b1, w);
      drain_check("single");
      log_en = 1'b0;
      checks++;
      if (w != 1) begin errors++; $display("FAIL single_latency: got %0d wait cycles, required 1", w); end
      checks++;
      if (src_log.size() != 3) begin
         errors++; $display("FAIL single_count: got %0d beats, required 3", src_log.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (t_log[i] - t_log[i-1] != 1) begin
               errors++; $display("FAIL single_spacing: got gap %0d cycles, required 1", t_log[i] - t_log[i-1]);
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap_gap;
      int w1, w2;
      send_pkt(1, 2, 8'h10, 1'b0, w1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #3;
         checks++;
         if (o_busy !== 1'b1) begin errors++; $display("FAIL gap_busy: got o_busy=%b in gap cycle %0d, required 1", o_busy, i); end
      end
      @(posedge clk); #1;
      send_pkt(1, 1, 8'h12, 1'b1, w2);
      checks++;
      if (w1 != 1 || w2 != 0) begin
         errors++; $display("FAIL gap_waits: got %0d/%0d wait cycles, required 1/0", w1, w2);
      end
      drain_check("wrap");
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL wrap_release: got o_busy=%b, required 0", o_busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      int w;
      fork
         send_pkt(0, 4, 8'h30, 1'b1, w);
         begin
            repeat (3) @(negedge clk);
            i_ready = 1'b0;
            repeat (5) begin
               @(negedge clk); #3;
               checks++;
               if (o_valid !== 1'b1 || o_data !== 8'h30 || o_ready !== '0) begin
                  errors++;
                  $display("FAIL backpressure_hold: got valid=%b data=%h ready=%b, required valid=1 data=30 ready=0000",
                           o_valid, o_data, o_ready);
               end
            end
            @(posedge clk); #1;
            i_ready = 1'b1;
         end
      join
      drain_check("backpressure");
      @(posedge clk); #1;
   endtask

   task automatic test_trunc;
      int w1, w2;
      int exp_src[9] = '{1, 1, 1, 1, 2, 1, 1, 1, 1};
      log_en = 1'b1; src_log.delete(); t_log.delete();
      fork
         send_pkt(1, 8, 8'h40, 1'b0, w1);
         send_pkt(2, 1, 8'h50, 1'b1, w2);
      join
      drain_check("trunc");
      log_en = 1'b0;
      checks++;
      if (src_log.size() != 9) begin
         errors++; $display("FAIL trunc_count: got %0d beats, required 9", src_log.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            checks++;
            if (src_log[i] != exp_src[i]) begin
               errors++; $display("FAIL trunc_order: beat %0d got src %0d, required %0d", i, src_log[i], exp_src[i]);
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset_fairness;
      int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      valid[3] = 1'b1; last[3] = 1'b0; data[3*W +: W] = 8'h60;
      @(posedge clk); #2;
      checks++;
      if (o_busy !== 1'b1 || o_ready !== 4'b1000) begin
         errors++; $display("FAIL pre_reset_grant: got busy=%b ready=%b, required busy=1 ready=1000", o_busy, o_ready);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({o_ready, o_valid, o_data, o_last, o_src, o_busy, o_trunc} !== '0) begin
         errors++;
         $display("FAIL async_reset: got ready=%b valid=%b data=%h last=%b src=%0d busy=%b trunc=%b, required all 0",
                  o_ready, o_valid, o_data, o_last, o_src, o_busy, o_trunc);
      end
      sb.delete();
      valid = '0; last = '0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      log_en = 1'b1; src_log.delete(); t_log.delete();
      fork
         two_pkts(0);
         two_pkts(1);
         two_pkts(2);
         two_pkts(3);
      join
      drain_check("fair");
      log_en = 1'b0;
      checks++;
      if (src_log.size() != 8) begin
         errors++; $display("FAIL fair_count: got %0d beats, required 8", src_log.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (src_log[i] != exp_order[i]) begin
               errors++; $display("FAIL fair_order: grant %0d got src %0d, required %0d", i, src_log[i], exp_order[i]);
            end
            if (i > 0) begin
               checks++;
               if (t_log[i] - t_log[i-1] != 2) begin
                  errors++; $display("FAIL fair_spacing: grant %0d got gap %0d cycles, required 2", i, t_log[i] - t_log[i-1]);
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_wrap_gap();
      test_backpressure();
      test_trunc();
      test_async_reset_fairness();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
